// File: rtl/latch_chain_seq_pkg.sv
// Shared definitions for the latch-chain sequencer: FSM encodings, pattern modes, PRBS7 constants.
// Latency: n/a (declarations and one pure helper function only).
// Backpressure: n/a.
package latch_chain_seq_pkg;

  // Sequencer FSM encoding, kept as plain constants for compatibility with older tools
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_P1   = 3'd1;
  localparam state_t ST_G1   = 3'd2;
  localparam state_t ST_P2   = 3'd3;
  localparam state_t ST_G2   = 3'd4;
  localparam state_t ST_FIN  = 3'd5;

  // Test pattern select, as presented on the mode pins
  typedef enum logic [1:0] {
    MODE_ZERO = 2'b00,
    MODE_ONE  = 2'b01,
    MODE_ALT  = 2'b10,
    MODE_PRBS = 2'b11
  } mode_e;

  // PRBS7, x^7 + x^6 + 1: output is the MSB, feedback is MSB xor the bit below it
  localparam logic [6:0] PRBS_SEED   = 7'h7F;
  localparam int         PRBS_TAP_HI = 6;
  localparam int         PRBS_TAP_LO = 5;

  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/latch_chain_patgen.sv
// Test pattern generator: registered bit = pattern index 0 after clear, next index after each advance.
// Latency: pat_bit reflects clear/advance one cycle later (registered output).
// Backpressure: none; advance is a single-cycle strobe. PRBS7 built only with LATCH_CHAIN_SEQ_PRBS_EN.
module latch_chain_patgen
  import latch_chain_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       clear,
  input  logic       advance,
  output logic       pat_bit
);

  logic alt_q;
  logic alt_nxt;
  logic bit_nxt;
`ifdef LATCH_CHAIN_SEQ_PRBS_EN
  logic [6:0] lfsr_q;
  logic [6:0] lfsr_nxt;
`endif

  // Next index state (clear reloads index 0) and the pattern bit it selects
  always_comb begin
    alt_nxt = alt_q;
`ifdef LATCH_CHAIN_SEQ_PRBS_EN
    lfsr_nxt = lfsr_q;
`endif
    if (clear) begin
      alt_nxt = 1'b1;
`ifdef LATCH_CHAIN_SEQ_PRBS_EN
      lfsr_nxt = PRBS_SEED;
`endif
    end else if (advance) begin
      alt_nxt = ~alt_q;
`ifdef LATCH_CHAIN_SEQ_PRBS_EN
      lfsr_nxt = prbs7_next(lfsr_q);
`endif
    end
    case (mode)
      MODE_ZERO: bit_nxt = 1'b0;
      MODE_ONE:  bit_nxt = 1'b1;
`ifdef LATCH_CHAIN_SEQ_PRBS_EN
      MODE_PRBS: bit_nxt = lfsr_nxt[PRBS_TAP_HI];
`endif
      // Alternating; also covers mode 11 when PRBS is not built
      default:   bit_nxt = alt_nxt;
    endcase
  end

  // Hold generator state between strobes so the bit stays flat for a whole step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alt_q   <= 1'b0;
      pat_bit <= 1'b0;
`ifdef LATCH_CHAIN_SEQ_PRBS_EN
      lfsr_q  <= PRBS_SEED;
`endif
    end else if (clear || advance) begin
      alt_q   <= alt_nxt;
      pat_bit <= bit_nxt;
`ifdef LATCH_CHAIN_SEQ_PRBS_EN
      lfsr_q  <= lfsr_nxt;
`endif
    end
  end

endmodule

// File: rtl/latch_chain_seq.sv
// Two-phase sequencer and self-test for a latch shift chain; optional PRBS7 mode via LATCH_CHAIN_SEQ_PRBS_EN.
// Latency: P1 one cycle after start; done at 1+(SR_LEN-1)(2+2*GAP) cycles after start.
// Backpressure: none; start is ignored while busy (no queueing), all outputs registered.
module latch_chain_seq
  import latch_chain_seq_pkg::*;
#(
  parameter int SR_LEN = 128,
  parameter int GAP    = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             sr_out,
  output logic             ph1,
  output logic             ph2,
  output logic             sr_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int DEPTH = SR_LEN / 2;
  localparam int KW    = $clog2(SR_LEN);
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [KW-1:0]    K_LAST   = KW'(SR_LEN - 2);
  localparam logic [KW-1:0]    K_CHK    = KW'(DEPTH - 1);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state_q;
  state_t           state_nxt;
  logic [KW-1:0]    k_q;
  logic [GW-1:0]    gap_q;
  logic [1:0]       mode_q;
  logic [1:0]       mode_eff;
  logic             accept;
  logic             gap_done;
  logic             last_step;
  logic             step_end;
  logic             sample_en;
  logic             mismatch;
  logic             exp_bit;
  logic [ERR_W-1:0] err_nxt;

  assign accept    = (state_q == ST_IDLE) && start;
  assign gap_done  = (gap_q == GAP_LAST);
  assign last_step = (k_q == K_LAST);
  assign step_end  = (state_q == ST_G2) && gap_done;
  // Chain output is only meaningful once the first driven bit has crossed all DEPTH stages
  assign sample_en = step_end && (k_q >= K_CHK);
  assign mismatch  = sample_en && (sr_out != exp_bit);
  // Generators are cleared on the accept edge, so they must see the mode pins directly then
  assign mode_eff  = (state_q == ST_IDLE) ? mode : mode_q;

  // Sequencer next state: P1, gap, P2, gap per step; FIN after the last step
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (start) state_nxt = ST_P1;
      ST_P1:   state_nxt = ST_G1;
      ST_G1:   if (gap_done) state_nxt = ST_P2;
      ST_P2:   state_nxt = ST_G2;
      ST_G2:   if (gap_done) state_nxt = last_step ? ST_FIN : ST_P1;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Error count for this run, saturating; cleared when a run is accepted
  always_comb begin
    err_nxt = err_cnt;
    if (accept) begin
      err_nxt = '0;
    end else if (mismatch && (err_cnt != ERR_MAX)) begin
      err_nxt = err_cnt + ERR_W'(1);
    end
  end

  // FSM state, step index and latched mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_nxt;
      if (accept) begin
        k_q    <= '0;
        mode_q <= mode;
      end else if (step_end && !last_step) begin
        k_q <= k_q + KW'(1);
      end
    end
  end

  // Dead-time counter, running only inside G1/G2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else if (((state_q == ST_G1) || (state_q == ST_G2)) && !gap_done) begin
      gap_q <= gap_q + GW'(1);
    end else begin
      gap_q <= '0;
    end
  end

  // Outputs registered from the next state so phases never glitch and nothing is combinational from pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph1     <= 1'b0;
      ph2     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      ph1     <= (state_nxt == ST_P1);
      ph2     <= (state_nxt == ST_P2);
      busy    <= (state_nxt == ST_P1) || (state_nxt == ST_G1) ||
                 (state_nxt == ST_P2) || (state_nxt == ST_G2);
      done    <= (state_nxt == ST_FIN);
      err_cnt <= err_nxt;
      // The final compare lands on the FIN-entry edge, so judge on the updated count
      if (accept) begin
        pass <= 1'b0;
      end else if (state_nxt == ST_FIN) begin
        pass <= (err_nxt == '0);
      end
    end
  end

  // Drive generator: index 0 on accept, next bit as each new step's P1 is entered
  latch_chain_patgen u_drv (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode_eff),
    .clear   (accept),
    .advance (step_end && !last_step),
    .pat_bit (sr_in)
  );

  // Expected generator: same pattern, stepping once per compare
  latch_chain_patgen u_exp (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode_eff),
    .clear   (accept),
    .advance (sample_en),
    .pat_bit (exp_bit)
  );

endmodule

// File: tb/tb_latch_chain_seq.sv
// Bench for latch_chain_seq: two instances (8 latches/GAP 1/8-bit count, 16 latches/GAP 2/2-bit count)
// each driving a behavioural latch chain; expectations are queued at start and checked by monitors.
module tb_latch_chain_seq;

  typedef struct {
    int         cyc;
    logic [7:0] err;
    logic       pas;
  } exp_run_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic       start_v [2];
  logic [1:0] mode_v  [2];
  logic       stuck_v [2];
  logic       ph1_v   [2];
  logic       ph2_v   [2];
  logic       sr_in_v [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       pass_v  [2];
  logic [7:0] err_v   [2];

  exp_run_t   run_q  [2][$];
  logic       bit_q  [2][$];
  int         busy_q [2][$];

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int L  = (g == 0) ? 8 : 16;
    localparam int GP = (g == 0) ? 1 : 2;
    localparam int EW = (g == 0) ? 8 : 2;

    logic          sr_out;
    logic          ph1, ph2, sr_in, busy, done, pass;
    logic [EW-1:0] err_cnt;
    logic          lat [L];
    logic          ph1_d = 1'b0;
    logic          ph2_d = 1'b0;
    logic          busy_d = 1'b0;
    int            ovl = 0;

    latch_chain_seq #(.SR_LEN(L), .GAP(GP), .ERR_W(EW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_v[g]),
      .mode    (mode_v[g]),
      .sr_out  (sr_out),
      .ph1     (ph1),
      .ph2     (ph2),
      .sr_in   (sr_in),
      .busy    (busy),
      .done    (done),
      .pass    (pass),
      .err_cnt (err_cnt)
    );

    assign sr_out     = stuck_v[g] ? 1'b0 : lat[L-1];
    assign ph1_v[g]   = ph1;
    assign ph2_v[g]   = ph2;
    assign sr_in_v[g] = sr_in;
    assign busy_v[g]  = busy;
    assign done_v[g]  = done;
    assign pass_v[g]  = pass;
    assign err_v[g]   = 8'(err_cnt);

    // Behavioural chain: even latches transparent while ph1, odd while ph2
    always @(negedge clk) begin
      if (ph1) begin
        for (int i = 2; i < L; i += 2) lat[i] = lat[i-1];
        lat[0] = sr_in;
      end
      if (ph2) begin
        for (int i = 1; i < L; i += 2) lat[i] = lat[i-1];
      end
    end

    // Monitor: phase spacing, run start, per-step drive bit, end-of-run result
    always @(negedge clk) begin
      int       want;
      logic     eb;
      exp_run_t r;
      if ((ph1 && ph2) || (ph1 && ph2_d) || (ph2 && ph1_d)) ovl++;
      ph1_d = ph1;
      ph2_d = ph2;
      if (busy && !busy_d) begin
        want = (busy_q[g].size() != 0) ? busy_q[g].pop_front() : -1;
        check("busy_rise_cycle", cyc, want);
        check("pass_cleared_at_start", int'(pass), 0);
        check("err_cleared_at_start", int'(err_cnt), 0);
      end
      busy_d = busy;
      if (ph1) begin
        if (bit_q[g].size() != 0) begin
          eb = bit_q[g].pop_front();
          check("sr_in_step", int'(sr_in), int'(eb));
        end else begin
          check("sr_in_unexpected_step", cyc, -1);
        end
      end
      if (done) begin
        if (run_q[g].size() != 0) begin
          r = run_q[g].pop_front();
          check("done_cycle", cyc, r.cyc);
          check("err_cnt", int'(err_cnt), int'(r.err));
          check("pass", int'(pass), int'(r.pas));
          check("busy_low_at_done", int'(busy), 0);
          check("phase_overlap", ovl, 0);
          ovl = 0;
        end else begin
          check("done_unexpected", cyc, -1);
        end
      end
    end
  end

  // Issue one start pulse and queue everything the run should produce
  task automatic start_run(input int g, input logic [1:0] m, input logic stk,
                           input logic [15:0] bits, input logic [7:0] err,
                           input logic pas, input logic full, output int c0);
    int len = (g == 0) ? 8 : 16;
    int gp  = (g == 0) ? 1 : 2;
    exp_run_t r;
    @(posedge clk); #1;
    c0 = cyc;
    start_v[g] = 1'b1;
    mode_v[g]  = m;
    stuck_v[g] = stk;
    busy_q[g].push_back(c0 + 1);
    for (int k = 0; k < len - 1; k++) bit_q[g].push_back(bits[k]);
    if (full) begin
      r.cyc = c0 + 1 + (len - 1) * (2 + 2 * gp);
      r.err = err;
      r.pas = pas;
      run_q[g].push_back(r);
    end
    @(posedge clk); #1;
    start_v[g] = 1'b0;
    mode_v[g]  = ~m;
  endtask

  task automatic wait_runs(input int budget);
    int n = 0;
    while ((run_q[0].size() + run_q[1].size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("runs_completed", run_q[0].size() + run_q[1].size(), 0);
    check("steps_consumed", bit_q[0].size() + bit_q[1].size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ph1"},   int'(ph1_v[0]), 0);
    check({tag, "_ph2"},   int'(ph2_v[0]), 0);
    check({tag, "_sr_in"}, int'(sr_in_v[0]), 0);
    check({tag, "_busy"},  int'(busy_v[0]), 0);
    check({tag, "_done"},  int'(done_v[0]), 0);
    check({tag, "_pass"},  int'(pass_v[0]), 0);
    check({tag, "_err"},   int'(err_v[0]), 0);
  endtask

  initial begin
    int c0;
    logic [15:0] prbs8, prbs16;
`ifdef LATCH_CHAIN_SEQ_PRBS_EN
    prbs8  = 16'h007F;
    prbs16 = 16'h207F;
`else
    prbs8  = 16'h5555;
    prbs16 = 16'h5555;
`endif
    for (int g = 0; g < 2; g++) begin
      start_v[g] = 1'b0;
      mode_v[g]  = 2'b00;
      stuck_v[g] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    // All-ones, healthy chain; a second start at cycle 10 must be ignored
    start_run(0, 2'b01, 1'b0, 16'hFFFF, 8'd0, 1'b1, 1'b1, c0);
    wait_cycle(c0 + 10);
    start_v[0] = 1'b1;
    mode_v[0]  = 2'b00;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_runs(200);

    // Alternating, healthy chain
    start_run(0, 2'b10, 1'b0, 16'h5555, 8'd0, 1'b1, 1'b1, c0);
    wait_runs(200);

    // Stuck-at-0 output with all-ones: 4 misses, and 8 misses saturating a 2-bit count
    start_run(0, 2'b01, 1'b1, 16'hFFFF, 8'd4, 1'b0, 1'b1, c0);
    start_run(1, 2'b01, 1'b1, 16'hFFFF, 8'd3, 1'b0, 1'b1, c0);
    wait_runs(300);
    check("pass_held_low", int'(pass_v[0]), 0);
    check("err_held", int'(err_v[0]), 4);

    // Mode 11: PRBS7 when built, alternating otherwise
    start_run(0, 2'b11, 1'b0, prbs8, 8'd0, 1'b1, 1'b1, c0);
    start_run(1, 2'b11, 1'b0, prbs16, 8'd0, 1'b1, 1'b1, c0);
    wait_runs(300);

    // Reset in the middle of step 3 (P2 cycle), then a clean run
    start_run(0, 2'b01, 1'b0, 16'hFFFF, 8'd0, 1'b1, 1'b0, c0);
    wait_cycle(c0 + 15);
    check("pre_reset_ph2", int'(ph2_v[0]), 1);
    check("pre_reset_sr_in", int'(sr_in_v[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    bit_q[0].delete();
    busy_q[0].delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_run(0, 2'b01, 1'b0, 16'hFFFF, 8'd0, 1'b1, 1'b1, c0);
    wait_runs(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/latch_chain_seq.md
# latch_chain_seq

Two-phase sequencer and self-test controller for the latch-based shift-register chain. Generates non-overlapping `ph1`/`ph2` enables from the single system clock with a programmable dead time. Drives a selectable test pattern into the chain input and checks the chain output against a delayed copy of that pattern. Reports an error count and a pass flag, and sits between the top-level pins/config and the latch array.

## Interface
- `SR_LEN`, 128: latches in the chain. Must be even and ≥4. Latch `i` is enabled by `ph1` for even `i` and by `ph2` for odd `i`. `DEPTH = SR_LEN/2` bit stages.
- `GAP`, 1: dead cycles, with both phases low, after each phase pulse. Must be ≥1.
- `ERR_W`, 8: width of the error counter.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: run request, sampled in IDLE only.
- `mode` in 2: pattern select, latched at start. 00 all-zeros, 01 all-ones, 10 alternating, 11 PRBS7.
- `sr_out` in 1: output of the last latch in the chain.
- `ph1` out 1: enable for the even latches.
- `ph2` out 1: enable for the odd latches.
- `sr_in` out 1: data into latch 0.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at the end of a run.
- `pass` out 1: valid after `done`, held until the next accepted start.
- `err_cnt` out ERR_W: saturating mismatch count for the last run.

## Operation
- **FSM states:** IDLE, P1, G1, P2, G2, FIN.
- **IDLE:**
  - `start`=1 → latch `mode`, clear `err_cnt`, clear `pass`, set step `k`=0, go to P1.
  - `start`=0 → stay in IDLE.
- **P1:** `ph1`=1 for 1 cycle → G1.
- **G1:** both phases low for `GAP` cycles → P2.
- **P2:** `ph2`=1 for 1 cycle → G2.
- **G2:** both phases low for `GAP` cycles.
  - On leaving G2: if `k`=SR_LEN-2 go to FIN; else increment `k` and go to P1.
- **FIN:** 1 cycle. `done`=1, `pass`=(`err_cnt`==0), `busy` falls, then → IDLE.
- **Overlap:** `ph1` and `ph2` are never high in the same cycle, and never in adjacent cycles.
- **Drive pattern:** `sr_in` = pattern bit `k`. It is updated on entry to P1 and held constant for the whole step.
- **Pattern bits:**
  - all-zeros: 0.
  - all-ones: 1.
  - alternating: bit `k` = ~`k`[0], giving 1,0,1,0…
  - PRBS7: x^7+x^6+1, seed 7'h7F. Output bit = `lfsr[6]`. Next state = {`lfsr[5:0]`, `lfsr[6]^lfsr[5]`}. First bit is 1.
- **Check:**
  - Fill latency: after step `k`, `sr_out` holds pattern bit `k-DEPTH+1`.
  - `sr_out` is sampled in the last G2 cycle of step `k`, for `k` ≥ DEPTH-1.
  - Sampled value is compared with an expected generator running the same pattern from index 0, which starts advancing at `k`=DEPTH-1.
  - Exactly DEPTH comparisons occur per run.
- **err_cnt:** increments on each mismatch, saturating at 2^ERR_W-1.
- **Start during a run:** `start` while `busy` is ignored. No restart and no queueing.
- **Reset mid-run:** returns to IDLE immediately and drops `ph1`/`ph2` asynchronously. Chain contents are undefined afterwards; the next run refills the chain.
- **Reset values:** `ph1`=0, `ph2`=0, `sr_in`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, FSM in IDLE.

## Timing
- **Step length:** 2+2·GAP cycles. There are SR_LEN-1 steps per run.
- **Start:** `start` high at cycle 0 (in IDLE) → P1 and `busy`=1 at cycle 1.
- **Done:** `done` at cycle 1+(SR_LEN-1)(2+2·GAP), with `busy`=0 in that same cycle. The next start can be accepted in the following cycle.
- **Update edges:** `err_cnt` updates on the edge that ends the sampling cycle. `pass` updates on the edge entering FIN.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `LATCH_CHAIN_SEQ_PRBS_EN` defined: PRBS7 mode is built. This adds two 7-bit LFSRs.
- Undefined: no LFSR logic. `mode`=11 behaves exactly as alternating (10).

## Structure
- **Package `latch_chain_seq_pkg`:** FSM state enum, mode enum (`MODE_ZERO`, `MODE_ONE`, `MODE_ALT`, `MODE_PRBS`), `PRBS_SEED`=7'h7F, PRBS tap positions.
- **Sub-module `latch_chain_patgen`:** one instance each for drive and expected.
  - Ports: clock, reset, mode, `clear`, `advance`, `bit`.
  - The macro applies inside it.

## Test plan
The bench models the chain behaviourally with alternating latch enables. Parameters are SR_LEN=8, GAP=1 unless stated otherwise.
- Reset, then `start` pulse with `mode`=01 at cycle 0 → `busy` at cycle 1; `done` at cycle 29; `err_cnt`=0; `pass`=1; `ph1`/`ph2` never high in the same or adjacent cycles.
- `mode`=10, healthy chain → `sr_in` sequence per step is 1,0,1,0,1,0,1; 4 compares; `pass`=1.
- `mode`=01 with `sr_out` stuck at 0 → `err_cnt`=4, `pass`=0. Repeat with ERR_W=2 → `err_cnt`=3 (saturated).
- `mode`=11 with the macro defined → first 7 driven bits are 1,1,1,1,1,1,1, then 0; `pass`=1. With the macro undefined → driven bits match the alternating pattern.
- `start` re-asserted at cycle 10 → ignored; `done` still at cycle 29. `rst_n` low at cycle 15 → phases drop and all outputs return to reset values asynchronously; the next start completes with `pass`=1.
